// File: rtl/mips_ctrl_decoder.sv
// Main control decoder for the single-issue MIPS core.
// Turns the opcode/funct of the current instruction into datapath control
// signals, registered once so every output appears one clock after instr.
module mips_ctrl_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        ExtOp,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic [1:0]  nPC_sel,
  output logic [2:0]  ALUctr,
  output logic        ExtHigh,
  output logic        JAL_PC,
  output logic        illegal
);

  typedef struct packed {
    logic       memWrite;
    logic       regWrite;
    logic       extOp;
    logic       aluSrc;
    logic       regDst;
    logic       memtoReg;
    logic [1:0] nPcSel;
    logic [2:0] aluCtr;
    logic       extHigh;
    logic       jalPc;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  // Pure decode of one instruction word. Anything unrecognised yields no
  // write and no PC redirect, only the illegal flag. nop is matched on the
  // whole word so that shifts with funct 000000 (e.g. sll) still trap.
  function automatic ctrl_t decodeInstr(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    unique case (ins[31:26])
      OP_RTYPE: begin
        if (ins == 32'h0000_0000) begin
          c = '0;
        end else begin
          unique case (ins[5:0])
            FN_ADDU: begin
              c.regWrite = 1'b1;
              c.regDst   = 1'b1;
              c.aluCtr   = ALU_ADD;
            end
            FN_SUBU: begin
              c.regWrite = 1'b1;
              c.regDst   = 1'b1;
              c.aluCtr   = ALU_SUB;
            end
            FN_JR:   c.nPcSel  = 2'b11;
            default: c.illegal = 1'b1;
          endcase
        end
      end
      OP_ORI: begin
        c.regWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.aluCtr   = ALU_OR;
      end
      OP_LUI: begin
        c.regWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.extHigh  = 1'b1;
        c.aluCtr   = ALU_OR;
      end
      OP_LW: begin
        c.regWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.extOp    = 1'b1;
        c.memtoReg = 1'b1;
        c.aluCtr   = ALU_ADD;
      end
      OP_SW: begin
        c.memWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.extOp    = 1'b1;
        c.aluCtr   = ALU_ADD;
      end
      OP_BEQ: begin
        c.extOp    = 1'b1;
        c.aluCtr   = ALU_SUB;
        c.nPcSel   = 2'b01;
      end
      OP_JAL: begin
        c.regWrite = 1'b1;
        c.jalPc    = 1'b1;
        c.nPcSel   = 2'b10;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Stage p0: combinational decode of the incoming word
  ctrl_t ctrlP0;
  ctrl_t ctrlP1;

  // Decode the instruction presented this cycle
  always_comb begin
    ctrlP0 = decodeInstr(instr);
  end

  // Stage p1: register the decode; active-low reset forces a quiet bundle
  always_ff @(posedge clk) begin
    if (!reset) ctrlP1 <= '0;
    else        ctrlP1 <= ctrlP0;
  end

  assign MemWrite = ctrlP1.memWrite;
  assign RegWrite = ctrlP1.regWrite;
  assign ExtOp    = ctrlP1.extOp;
  assign ALUSrc   = ctrlP1.aluSrc;
  assign RegDst   = ctrlP1.regDst;
  assign MemtoReg = ctrlP1.memtoReg;
  assign nPC_sel  = ctrlP1.nPcSel;
  assign ALUctr   = ctrlP1.aluCtr;
  assign ExtHigh  = ctrlP1.extHigh;
  assign JAL_PC   = ctrlP1.jalPc;
  assign illegal  = ctrlP1.illegal;

endmodule

// File: tb/tb_mips_ctrl_decoder.sv
// Testbench for mips_ctrl_decoder: directed instruction sequence followed by
// a randomised opcode/funct sweep against a mask/pattern reference table.
module tb_mips_ctrl_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        MemWrite, RegWrite, ExtOp, ALUSrc, RegDst, MemtoReg;
  logic [1:0]  nPC_sel;
  logic [2:0]  ALUctr;
  logic        ExtHigh, JAL_PC, illegal;

  int checks = 0;
  int failures = 0;

  mips_ctrl_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .ExtOp    (ExtOp),
    .ALUSrc   (ALUSrc),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .nPC_sel  (nPC_sel),
    .ALUctr   (ALUctr),
    .ExtHigh  (ExtHigh),
    .JAL_PC   (JAL_PC),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // Output vector order: MemWrite RegWrite ExtOp ALUSrc RegDst MemtoReg
  // nPC_sel[1:0] ALUctr[2:0] ExtHigh JAL_PC illegal
  function automatic logic [13:0] mk(input logic mw, input logic rw,
                                     input logic eo, input logic as,
                                     input logic rd, input logic m2r,
                                     input logic [1:0] npc, input logic [2:0] alu,
                                     input logic eh, input logic jal,
                                     input logic ill);
    return {mw, rw, eo, as, rd, m2r, npc, alu, eh, jal, ill};
  endfunction

  // Reference: first matching row of a (mask, pattern) table wins;
  // a word matching no row is illegal.
  function automatic logic [13:0] refDecode(input logic [31:0] w);
    logic [31:0] mask [10];
    logic [31:0] pat  [10];
    logic [13:0] res  [10];
    mask[0] = 32'hffffffff; pat[0] = 32'h00000000; res[0] = mk(0,0,0,0,0,0,2'd0,3'd0,0,0,0); // nop
    mask[1] = 32'hfc00003f; pat[1] = 32'h00000021; res[1] = mk(0,1,0,0,1,0,2'd0,3'd0,0,0,0); // addu
    mask[2] = 32'hfc00003f; pat[2] = 32'h00000023; res[2] = mk(0,1,0,0,1,0,2'd0,3'd1,0,0,0); // subu
    mask[3] = 32'hfc00003f; pat[3] = 32'h00000008; res[3] = mk(0,0,0,0,0,0,2'd3,3'd0,0,0,0); // jr
    mask[4] = 32'hfc000000; pat[4] = 32'h34000000; res[4] = mk(0,1,0,1,0,0,2'd0,3'd2,0,0,0); // ori
    mask[5] = 32'hfc000000; pat[5] = 32'h3c000000; res[5] = mk(0,1,0,1,0,0,2'd0,3'd2,1,0,0); // lui
    mask[6] = 32'hfc000000; pat[6] = 32'h8c000000; res[6] = mk(0,1,1,1,0,1,2'd0,3'd0,0,0,0); // lw
    mask[7] = 32'hfc000000; pat[7] = 32'hac000000; res[7] = mk(1,0,1,1,0,0,2'd0,3'd0,0,0,0); // sw
    mask[8] = 32'hfc000000; pat[8] = 32'h10000000; res[8] = mk(0,0,1,0,0,0,2'd1,3'd1,0,0,0); // beq
    mask[9] = 32'hfc000000; pat[9] = 32'h0c000000; res[9] = mk(0,1,0,0,0,0,2'd2,3'd0,0,1,0); // jal
    for (int i = 0; i < 10; i++)
      if ((w & mask[i]) == pat[i]) return res[i];
    return mk(0,0,0,0,0,0,2'd0,3'd0,0,0,1);
  endfunction

  task automatic check(input string tag, input logic [13:0] exp);
    logic [13:0] got;
    got = {MemWrite, RegWrite, ExtOp, ALUSrc, RegDst, MemtoReg,
           nPC_sel, ALUctr, ExtHigh, JAL_PC, illegal};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    checks++;
    assert ($countones({MemWrite, JAL_PC, MemtoReg}) <= 1) else begin
      failures++;
      $error("FAIL %s_exclusive observed=%b expected=at_most_one", tag,
             {MemWrite, JAL_PC, MemtoReg});
    end
  endtask

  // Drive one word for one edge, then compare just after that edge.
  task automatic step(input string tag, input logic [31:0] w, input logic r,
                      input logic [13:0] exp);
    instr = w;
    reset = r;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  localparam logic [13:0] Z    = 14'h0;
  localparam logic [13:0] ORI  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,3'b010,1'b0,1'b0,1'b0};
  localparam logic [13:0] JAL  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,3'b000,1'b0,1'b1,1'b0};
  localparam logic [13:0] ADDU = {1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0};
  localparam logic [13:0] SUBU = {1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,3'b001,1'b0,1'b0,1'b0};
  localparam logic [13:0] SW   = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0};
  localparam logic [13:0] LW   = {1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'b00,3'b000,1'b0,1'b0,1'b0};
  localparam logic [13:0] BEQ  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,3'b001,1'b0,1'b0,1'b0};
  localparam logic [13:0] LUI  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,3'b010,1'b1,1'b0,1'b0};
  localparam logic [13:0] JR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,1'b0,1'b0,1'b0};
  localparam logic [13:0] ILL  = 14'h0001;

  initial begin
    logic [5:0]  ops [8];
    logic [5:0]  fns [4];
    logic [31:0] w;
    logic        r;
    ops = '{6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h03, 6'h00};
    fns = '{6'h21, 6'h23, 6'h08, 6'h00};

    // Reset held for two edges with an ori on the bus
    step("reset0", 32'h341c0000, 1'b0, Z);
    step("reset1", 32'h341c0000, 1'b0, Z);
    step("ori",    32'h341c0000, 1'b1, ORI);
    step("jal",    32'h0c000c01, 1'b1, JAL);

    // Back-to-back stream
    step("addu", 32'h00851021, 1'b1, ADDU);
    step("subu", 32'h00851023, 1'b1, SUBU);
    step("sw",   32'hac220004, 1'b1, SW);
    step("lw",   32'h8c220004, 1'b1, LW);
    step("beq",  32'h10220003, 1'b1, BEQ);
    step("lui",  32'h3c01abcd, 1'b1, LUI);
    step("jr",   32'h03e00008, 1'b1, JR);

    // nop versus unsupported words
    step("nop",      32'h00000000, 1'b1, Z);
    step("badop",    32'hfc000000, 1'b1, ILL);
    step("badfunct", 32'h0000003f, 1'b1, ILL);
    step("sll",      32'h00021080, 1'b1, ILL);

    // Reset asserted while sw streams, then released
    step("sw_pre",  32'hac220004, 1'b1, SW);
    step("sw_rst",  32'hac220004, 1'b0, Z);
    step("sw_post", 32'hac220004, 1'b1, SW);

    // Randomised sweep against the reference table
    for (int i = 0; i < 1000; i++) begin
      w = $urandom();
      if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 7)];
      if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0)
        w[5:0] = fns[$urandom_range(0, 3)];
      if ($urandom_range(0, 19) == 0) w = 32'h0;
      r = ($urandom_range(0, 49) != 0);
      step("random", w, r, r ? refDecode(w) : Z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_decoder.md
Name: mips_ctrl_decoder

Overview:
- Main control decoder for the single-issue MIPS CPU; sits between instruction fetch/decode and the datapath muxes, ALU, data memory and next-PC logic.
- Decodes a 32-bit instruction (opcode [31:26], funct [5:0]) into datapath control signals.
- All outputs are registered: one clock of latency.
- Also flags unsupported instructions.

Parameters:
- None.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- instr  input  32  instruction word to decode
- MemWrite  output  1  data memory write enable
- RegWrite  output  1  register file write enable
- ExtOp  output  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- ALUSrc  output  1  ALU B operand: 1 = extended immediate, 0 = rt
- RegDst  output  1  write register: 1 = rd, 0 = rt
- MemtoReg  output  1  writeback source: 1 = memory data, 0 = ALU result
- nPC_sel  output  2  next PC: 00 = PC+4, 01 = beq branch, 10 = jump target (instr[25:0]), 11 = register (jr)
- ALUctr  output  3  ALU op: 000 = ADD, 001 = SUB, 010 = OR; other codes unused
- ExtHigh  output  1  1 = immediate placed in bits [31:16], low half zero (lui)
- JAL_PC  output  1  1 = write PC+4 to $31 (jal)
- illegal  output  1  instruction not in the supported set

Behaviour:
- One clock domain: clk.
- reset is synchronous and active-low. When reset = 0 at a rising clk edge, every output clears to 0 (nPC_sel = 00, ALUctr = 000, illegal = 0).
- Otherwise, at each rising edge all outputs register the decode of the instr value present at that edge.
- Latency is exactly 1 cycle. There is no handshake; a new instruction is accepted every cycle.
- Outputs hold their value between edges.
- Signals not listed in an instruction's row below are 0.
- addu (op 000000, funct 100001): RegWrite=1, RegDst=1, ALUctr=000.
- subu (op 000000, funct 100011): RegWrite=1, RegDst=1, ALUctr=001.
- jr (op 000000, funct 001000): nPC_sel=11.
- nop (instr == 32'h00000000): all 0, illegal=0.
- Any other op-000000 funct: all 0, illegal=1.
- ori (op 001101): RegWrite=1, ALUSrc=1, ExtOp=0, ALUctr=010.
- lui (op 001111): RegWrite=1, ALUSrc=1, ExtHigh=1, ALUctr=010.
- lw (op 100011): RegWrite=1, ALUSrc=1, ExtOp=1, MemtoReg=1, ALUctr=000.
- sw (op 101011): MemWrite=1, ALUSrc=1, ExtOp=1, ALUctr=000.
- beq (op 000100): ExtOp=1, ALUctr=001, nPC_sel=01.
- jal (op 000011): RegWrite=1, JAL_PC=1, nPC_sel=10.
- Any other opcode: all control outputs 0, illegal=1. Unknown instructions never cause a write or a PC redirect.
- Decode depends only on opcode and, for op 000000, on funct. rs/rt/rd/shamt/immediate bits are ignored, except that nop is detected by the full word.
- At most one of MemWrite, JAL_PC and MemtoReg is 1 in any cycle.
- Reset asserted mid-stream: the outputs of the next edge are all 0, regardless of instr.
- Decoding resumes on the first edge with reset = 1.
- instr containing X/Z is outside the contract.

Test Plan:
- Hold reset=0 for 2 edges with instr=32'h341c0000 -> all outputs 0. Release reset; after 1 edge: RegWrite=1, ALUSrc=1, ExtOp=0, ALUctr=010, others 0.
- instr=32'h0c000c01 (jal) -> after 1 edge: RegWrite=1, JAL_PC=1, nPC_sel=10, MemWrite=0, ALUSrc=0, illegal=0.
- Back-to-back every cycle, checking one-cycle-delayed outputs per the table above: 32'h00851021 (addu), 32'h00851023 (subu), 32'hac220004 (sw), 32'h8c220004 (lw), 32'h10220003 (beq), 32'h3c01abcd (lui), 32'h03e00008 (jr).
- instr=32'h00000000 -> all 0, illegal=0. instr=32'hfc000000 -> all 0, illegal=1. instr=32'h0000003f -> all 0, illegal=1.
- Assert reset=0 while sw is streaming -> the next edge gives MemWrite=0 and all outputs 0. Release reset -> the sw decode reappears one edge later.
- Randomised opcode/funct sweep (1000 cycles) against a reference table -> exact match on every output, including illegal.
